memory_access_controller: RTL and testbench

Sequences single-word reads and writes between the core and external memory using a four-phase req/ack handshake. It sits directly downstream of `data_register_controller`:
- its read address comes from `o_mem_read_addr`, which is either the program counter or AR;
- its write data comes from `o_register_output`;
- the returned word is driven back onto the core `i_data` bus.

A timeout abandons transfers the memory never acknowledges.

---
 rtl/memory_access_controller_pkg.sv | 31 +++
 rtl/memory_access_controller.sv | 113 +++++++++++
 tb/tb_memory_access_controller.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_controller_pkg.sv
// ============================================================================
// memory_access_controller_pkg
// Shared width, state encoding and timeout helper for the memory access
// controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package memory_access_controller_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int CNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        MAC_IDLE    = 2'd0,
        MAC_WAIT    = 2'd1,
        MAC_RELEASE = 2'd2
    } mac_state_t;

    // True on the WAIT cycle whose edge brings the count up to the limit.
    // Widened by one bit so a count of 255 can never wrap into a false miss.
    function automatic logic timeout_hit(
        input logic [CNT_WIDTH-1:0] count,
        input logic [CNT_WIDTH-1:0] limit
    );
        return ({1'b0, count} + 9'd1) >= {1'b0, limit};
    endfunction

endpackage

`default_nettype wire

// File: rtl/memory_access_controller.sv
// ============================================================================
// memory_access_controller
// Single-word read/write sequencer with four-phase req/ack handshake and
// timeout on unacknowledged transfers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_access_controller
    import memory_access_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rd_start,
    input  logic                  i_wr_start,
    input  logic [DATA_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam logic [CNT_WIDTH-1:0] c_timeout = CNT_WIDTH'(TIMEOUT_CYCLES);

    mac_state_t           r_state;
    logic [CNT_WIDTH-1:0] r_count;

    logic w_start;
    logic w_is_write;

    // Read has priority when both starts arrive together.
    assign w_start    = i_rd_start | i_wr_start;
    assign w_is_write = i_wr_start & ~i_rd_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= MAC_IDLE;
            r_count     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_rdata     <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_done  <= 1'b0;
            o_error <= 1'b0;

            case (r_state)
                MAC_IDLE: begin
                    // A lingering ack from an abandoned transfer blocks new work.
                    if (w_start && !i_mem_ack) begin
                        o_mem_addr <= i_addr;
                        if (w_is_write) begin
                            o_mem_wdata <= i_wdata;
                        end
                        o_mem_we  <= w_is_write;
                        o_mem_req <= 1'b1;
                        o_busy    <= 1'b1;
                        r_count   <= '0;
                        r_state   <= MAC_WAIT;
                    end
                end

                MAC_WAIT: begin
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        if (!o_mem_we) begin
                            o_rdata <= i_mem_rdata;
                        end
                        r_state <= MAC_RELEASE;
                    end else if (timeout_hit(r_count, c_timeout)) begin
                        o_mem_req <= 1'b0;
                        o_error   <= 1'b1;
                        o_busy    <= 1'b0;
                        r_state   <= MAC_IDLE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                MAC_RELEASE: begin
                    o_mem_req <= 1'b0;
                    if (!i_mem_ack) begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= MAC_IDLE;
                    end
                end

                default: begin
                    o_mem_req <= 1'b0;
                    o_busy    <= 1'b0;
                    r_state   <= MAC_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_access_controller.sv
// ============================================================================
// tb_memory_access_controller
// Directed and randomized transfers against a one-cycle-latency memory model
// and a word-level reference of memory contents and read-back data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_access_controller;
    import memory_access_controller_pkg::*;

    localparam int TO = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  i_rd_start;
    logic                  i_wr_start;
    logic [DATA_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_mem_req;
    logic                  o_mem_we;
    logic [DATA_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic                  mem_ack = 1'b0;
    logic [DATA_WIDTH-1:0] mem_rdata;

    always #5 clk = ~clk;

    memory_access_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_start (i_rd_start),
        .i_wr_start (i_wr_start),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_rdata    (o_rdata),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_ack  (mem_ack),
        .i_mem_rdata(mem_rdata)
    );

    function automatic logic [15:0] init_word(input logic [7:0] a);
        return 16'({8'h00, a} * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Memory model: ack follows req one cycle late (mode 0), never acks
    // (mode 1), or follows force_ack (mode 2).
    logic [15:0] mem [0:255];
    int          ack_mode  = 0;
    logic        force_ack = 1'b0;
    logic        mem_init  = 1'b1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
        end else if (ack_mode == 0 && o_mem_req && !mem_ack && o_mem_we) begin
            mem[o_mem_addr[7:0]] <= o_mem_wdata;
        end
        case (ack_mode)
            0:       mem_ack <= o_mem_req;
            1:       mem_ack <= 1'b0;
            default: mem_ack <= force_ack;
        endcase
    end

    assign mem_rdata = mem_ack ? mem[o_mem_addr[7:0]] : 16'hDEAD;

    // Reference: what memory should hold and what o_rdata should show.
    logic [15:0] ref_mem [0:255];
    logic [15:0] exp_rdata;
    int          n_checks = 0;
    int          n_fails  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer with a well-behaved memory: req high E0..E2, done after E4.
    task automatic xfer(input bit do_wr, input bit both, input bit poke,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input string tag);
        logic exp_we;
        exp_we     = do_wr && !both;
        i_addr     = addr;
        i_wdata    = wdata;
        i_rd_start = !do_wr || both;
        i_wr_start = do_wr || both;
        tick();
        i_rd_start = poke;
        i_wr_start = 1'b0;
        check({tag, "/req_e0"},   16'(o_mem_req), 16'd1);
        check({tag, "/busy_e0"},  16'(o_busy),    16'd1);
        check({tag, "/we_e0"},    16'(o_mem_we),  16'(exp_we));
        check({tag, "/addr_e0"},  o_mem_addr,     addr);
        check({tag, "/done_e0"},  16'(o_done),    16'd0);
        check({tag, "/err_e0"},   16'(o_error),   16'd0);
        if (exp_we) check({tag, "/wdata_e0"}, o_mem_wdata, wdata);
        tick();
        i_rd_start = 1'b0;
        check({tag, "/req_e1"},   16'(o_mem_req), 16'd1);
        if (exp_we) ref_mem[addr[7:0]] = wdata;
        else        exp_rdata = ref_mem[addr[7:0]];
        tick();
        check({tag, "/req_e2"},   16'(o_mem_req), 16'd0);
        check({tag, "/rdata_e2"}, o_rdata,        exp_rdata);
        check({tag, "/busy_e2"},  16'(o_busy),    16'd1);
        tick();
        check({tag, "/done_e3"},  16'(o_done),    16'd0);
        tick();
        check({tag, "/done_e4"},  16'(o_done),    16'd1);
        check({tag, "/busy_e4"},  16'(o_busy),    16'd0);
        check({tag, "/err_e4"},   16'(o_error),   16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        i_rd_start = 1'b0;
        i_wr_start = 1'b0;
        i_addr     = '0;
        i_wdata    = '0;
        exp_rdata  = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));

        tick();
        tick();
        check("rst/busy",  16'(o_busy),    16'd0);
        check("rst/done",  16'(o_done),    16'd0);
        check("rst/err",   16'(o_error),   16'd0);
        check("rst/req",   16'(o_mem_req), 16'd0);
        check("rst/we",    16'(o_mem_we),  16'd0);
        check("rst/rdata", o_rdata,        16'd0);
        check("rst/addr",  o_mem_addr,     16'd0);
        check("rst/wdata", o_mem_wdata,    16'd0);
        mem_init = 1'b0;
        rst_n    = 1'b1;
        tick();

        xfer(1'b1, 1'b0, 1'b0, 16'h0008, 16'h1234, "wr08");
        xfer(1'b1, 1'b0, 1'b0, 16'h0040, 16'hBEEF, "wr40");
        xfer(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, "rd40");
        check("rd40/value", o_rdata, 16'hBEEF);

        // Both starts together, plus a start poked during WAIT.
        xfer(1'b1, 1'b1, 1'b1, 16'h0008, 16'hFFFF, "both");
        check("both/value", o_rdata, 16'h1234);
        tick();
        check("poke/done", 16'(o_done),    16'd0);
        check("poke/busy", 16'(o_busy),    16'd0);
        check("poke/req",  16'(o_mem_req), 16'd0);

        // Timeout with a silent memory.
        ack_mode   = 1;
        i_addr     = 16'h0123;
        i_rd_start = 1'b1;
        tick();
        i_rd_start = 1'b0;
        for (int k = 0; k < TO; k++) begin
            check("to/req_wait", 16'(o_mem_req), 16'd1);
            check("to/err_wait", 16'(o_error),   16'd0);
            tick();
        end
        check("to/err",   16'(o_error),   16'd1);
        check("to/req",   16'(o_mem_req), 16'd0);
        check("to/busy",  16'(o_busy),    16'd0);
        check("to/rdata", o_rdata,        exp_rdata);
        tick();
        check("to/err_pulse", 16'(o_error), 16'd0);

        // Late ack holds off a new start until it drops.
        ack_mode  = 2;
        force_ack = 1'b1;
        tick();
        i_addr     = 16'h0008;
        i_rd_start = 1'b1;
        tick();
        check("late/busy", 16'(o_busy),    16'd0);
        check("late/req",  16'(o_mem_req), 16'd0);
        i_rd_start = 1'b0;
        force_ack  = 1'b0;
        tick();
        ack_mode = 0;
        tick();
        xfer(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, "after_late");

        // Asynchronous reset in the middle of WAIT.
        i_addr     = 16'h0008;
        i_rd_start = 1'b1;
        tick();
        i_rd_start = 1'b0;
        check("mid/req_pre", 16'(o_mem_req), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid/req",   16'(o_mem_req), 16'd0);
        check("mid/busy",  16'(o_busy),    16'd0);
        check("mid/rdata", o_rdata,        16'd0);
        exp_rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        xfer(1'b0, 1'b0, 1'b0, 16'h0008, 16'h0000, "after_rst");
        check("after_rst/value", o_rdata, 16'h1234);

        // Random back-to-back traffic over a small address window.
        for (int n = 0; n < 24; n++) begin
            logic        r_wr;
            logic        r_both;
            logic [15:0] r_addr;
            logic [15:0] r_data;
            r_wr   = 1'($urandom_range(0, 1));
            r_both = ($urandom_range(0, 7) == 0);
            r_addr = {8'($urandom), 4'h0, 4'($urandom)};
            r_data = 16'($urandom);
            xfer(r_wr, r_both, 1'b0, r_addr, r_data, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
